// File: rtl/pipe_pkg.sv
// Shared types for the valid/stall pipe family (burst source, sink, checker).
package pipe_pkg;

   // Burst source control state: IDLE waits for a command, RUN emits beats.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pipe_src_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_burst_src.sv
// Burst source: takes one (seed, step, len) command, emits len+1 beats of an
// arithmetic sequence on a registered valid/stall output. A new command is
// accepted on the cycle the last beat transfers, so bursts chain with no bubble.
module pipe_burst_src
   import pipe_pkg::*;
#(
   parameter int DW   = 32,
   parameter int LENW = 8,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            cmd_valid,
   output logic            cmd_stall,
   input  logic [LENW-1:0] cmd_len,
   input  logic [DW-1:0]   cmd_seed,
   input  logic [DW-1:0]   cmd_step,
   output logic            o_valid,
   output logic [DW-1:0]   o_data,
   output logic            o_last,
   input  logic            o_stall,
   output logic            busy,
   output logic            burst_done,
   input  logic            cnt_clr,
   output logic [CNTW-1:0] burst_cnt
);

   pipe_src_state_e state_q, state_d;
   logic [LENW-1:0] rem_q, rem_d;
   logic [DW-1:0]   step_q, step_d;
   logic [DW-1:0]   data_d;
   logic            vld_d, last_d;
   logic            out_xfer, last_xfer, cmd_xfer;

   // Handshake decode; the command port only opens when idle or when the
   // final beat is leaving this cycle.
   always_comb begin
      out_xfer  = o_valid & ~o_stall;
      last_xfer = out_xfer & o_last;
      cmd_stall = busy & ~last_xfer;
      cmd_xfer  = cmd_valid & ~cmd_stall;
   end

   // Next-state and next-beat logic; outputs hold unless a transfer occurs.
   always_comb begin
      state_d = state_q;
      vld_d   = o_valid;
      data_d  = o_data;
      last_d  = o_last;
      rem_d   = rem_q;
      step_d  = step_q;
      case (state_q)
         IDLE: begin
            if (cmd_xfer) begin
               state_d = RUN;
               vld_d   = 1'b1;
               data_d  = cmd_seed;
               last_d  = (cmd_len == '0);
               rem_d   = cmd_len;
               step_d  = cmd_step;
            end
         end
         RUN: begin
            if (out_xfer) begin
               if (!o_last) begin
                  // Sum wraps modulo 2^DW by truncation.
                  data_d = o_data + step_q;
                  rem_d  = rem_q - 1'b1;
                  last_d = (rem_q == LENW'(1));
               end else if (cmd_xfer) begin
                  // Back-to-back reload: first beat of the next burst follows
                  // the last beat of this one with no idle cycle.
                  data_d = cmd_seed;
                  last_d = (cmd_len == '0);
                  rem_d  = cmd_len;
                  step_d = cmd_step;
               end else begin
                  state_d = IDLE;
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and control registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_last     <= 1'b0;
         rem_q      <= '0;
         step_q     <= '0;
         burst_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         o_valid    <= vld_d;
         o_data     <= data_d;
         o_last     <= last_d;
         rem_q      <= rem_d;
         step_q     <= step_d;
         burst_done <= last_xfer;
      end
   end

   assign busy = (state_q == RUN);

   // Completed-burst counter: clear wins over a coincident increment,
   // increment saturates at all-ones.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         burst_cnt <= '0;
      else if (cnt_clr)
         burst_cnt <= '0;
      else if (burst_done && (burst_cnt != {CNTW{1'b1}}))
         burst_cnt <= burst_cnt + 1'b1;
   end

endmodule : pipe_burst_src

// File: tb/tb_pipe_burst_src.sv
// Scoreboard bench for pipe_burst_src: stimulus pushes expected beats, a
// negedge monitor pops and compares every transfer and checks hold/done rules.
module tb_pipe_burst_src;

   localparam int DW   = 32;
   localparam int LENW = 8;
   localparam int CNTW = 16;

   logic            clk = 1'b0;
   logic            arst_n = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_stall;
   logic [LENW-1:0] cmd_len = '0;
   logic [DW-1:0]   cmd_seed = '0;
   logic [DW-1:0]   cmd_step = '0;
   logic            o_valid;
   logic [DW-1:0]   o_data;
   logic            o_last;
   logic            o_stall = 1'b0;
   logic            busy;
   logic            burst_done;
   logic            cnt_clr = 1'b0;
   logic [CNTW-1:0] burst_cnt;

   always #5 clk = ~clk;

   pipe_burst_src #(.DW(DW), .LENW(LENW), .CNTW(CNTW)) dut (
      .clk(clk), .arst_n(arst_n),
      .cmd_valid(cmd_valid), .cmd_stall(cmd_stall), .cmd_len(cmd_len),
      .cmd_seed(cmd_seed), .cmd_step(cmd_step),
      .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_stall(o_stall),
      .busy(busy), .burst_done(burst_done), .cnt_clr(cnt_clr), .burst_cnt(burst_cnt)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: pop/compare on each transfer, verify hold while stalled and
   // burst_done one cycle after each last-beat transfer.
   logic  prev_hold = 1'b0;
   logic  prev_lastx = 1'b0;
   beat_t prev_beat;
   beat_t mon_e;
   always @(negedge clk) begin
      if (!arst_n) begin
         prev_hold  = 1'b0;
         prev_lastx = 1'b0;
      end else begin
         chk("burst_done", burst_done, prev_lastx);
         if (prev_hold) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_data", o_data, prev_beat.data);
            chk("hold_last", o_last, prev_beat.last);
         end
         if (o_valid && !o_stall) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h want none", o_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("beat_data", o_data, mon_e.data);
               chk("beat_last", o_last, mon_e.last);
            end
         end
         prev_hold      = o_valid && o_stall;
         prev_beat.data = o_data;
         prev_beat.last = o_last;
         prev_lastx     = o_valid && !o_stall && o_last;
      end
   end

   // Present a command, queue its expected beats, return once accepted.
   task automatic send_cmd(input logic [DW-1:0] seed, input logic [DW-1:0] step,
                           input logic [LENW-1:0] len, output int cyc);
      logic [DW-1:0] d;
      beat_t         b;
      logic          acc;
      cmd_seed  = seed;
      cmd_step  = step;
      cmd_len   = len;
      cmd_valid = 1'b1;
      d = seed;
      for (int k = 0; k <= int'(len); k++) begin
         b.data = d;
         b.last = (k == int'(len));
         exp_q.push_back(b);
         d = d + step;
      end
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 1000) begin
         @(negedge clk);
         acc = !cmd_stall;
         @(posedge clk);
         #1;
         cyc++;
      end
      cmd_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL cmd_accept_timeout: got stalled want accepted");
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got busy/pending=%0d want drained", exp_q.size());
      end
   endtask

   task automatic wait_data(input logic [DW-1:0] v);
      int n = 0;
      while (!(o_valid && o_data == v) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL wait_data: got %0h want %0h", o_data, v);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      // Reset state.
      #12;
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", burst_done, 0);
      chk("rst_cnt", burst_cnt, 0);
      @(posedge clk); #1;
      arst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_cmd_stall", cmd_stall, 0);

      // Plain burst 5,8,11,14 on four consecutive cycles.
      send_cmd(32'd5, 32'd3, 8'd3, cyc);
      for (int i = 0; i < 4; i++) begin
         chk("t1_valid", o_valid, 1);
         chk("t1_busy", busy, 1);
         @(posedge clk); #1;
      end
      chk("t1_valid_end", o_valid, 0);
      wait_idle();
      @(posedge clk); #1;
      chk("t1_cnt", burst_cnt, 1);

      // Same burst, downstream stalls three cycles on beat 8.
      send_cmd(32'd5, 32'd3, 8'd3, cyc);
      wait_data(32'd8);
      o_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_cmd_stall", cmd_stall, 1);
         chk("t2_data", o_data, 8);
         chk("t2_last", o_last, 0);
         @(posedge clk); #1;
      end
      o_stall = 1'b0;
      wait_idle();
      @(posedge clk); #1;
      chk("t2_cnt", burst_cnt, 2);

      // Back-to-back: single-beat burst then a two-beat burst, no bubble.
      send_cmd(32'hFFFF_FFFF, 32'd7, 8'd0, cyc);
      send_cmd(32'd0, 32'd1, 8'd1, cyc);
      chk("t3_accept_cycles", cyc, 1);
      chk("t3_valid_b1", o_valid, 1);
      @(posedge clk); #1;
      chk("t3_valid_b2", o_valid, 1);
      wait_idle();
      @(posedge clk); #1;
      chk("t3_cnt", burst_cnt, 4);

      // Data wrap through 2^DW.
      send_cmd(32'hFFFF_FFFE, 32'd1, 8'd2, cyc);
      wait_idle();
      @(posedge clk); #1;
      chk("t4_cnt", burst_cnt, 5);

      // Clear, then reset in the middle of a burst.
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("clr_cnt", burst_cnt, 0);
      send_cmd(32'd100, 32'd10, 8'd7, cyc);
      wait_data(32'd120);
      #2;
      arst_n = 1'b0;
      #1;
      chk("r_valid", o_valid, 0);
      chk("r_busy", busy, 0);
      chk("r_cnt", burst_cnt, 0);
      chk("r_cmd_stall", cmd_stall, 0);
      exp_q.delete();
      @(posedge clk); #1;
      arst_n = 1'b1;
      send_cmd(32'd200, 32'd1, 8'd2, cyc);
      chk("r_first_beat", o_data, 200);
      wait_idle();
      @(posedge clk); #1;
      chk("r_cnt_after", burst_cnt, 1);

      // Drive the counter to saturation with chained single-beat bursts.
      for (int i = 0; i < 65534; i++)
         send_cmd(DW'(i), 32'd0, 8'd0, cyc);
      wait_idle();
      @(posedge clk); #1;
      chk("sat_cnt", burst_cnt, 16'hFFFF);
      send_cmd(32'd1, 32'd1, 8'd0, cyc);
      wait_idle();
      @(posedge clk); #1;
      chk("sat_hold", burst_cnt, 16'hFFFF);

      // Clear coincident with burst_done wins.
      send_cmd(32'd2, 32'd1, 8'd0, cyc);
      @(posedge clk); #1;
      chk("clr_done_high", burst_done, 1);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("clr_prio", burst_cnt, 0);
      wait_idle();
      @(posedge clk); #1;
      chk("clr_stays", burst_cnt, 0);
      chk("final_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pipe_burst_src
